resp_tx: RTL and testbench
==========================

Name: resp_tx

Overview:
Response transmitter of the SUMP-compatible analyzer, on the outbound side of the command path. It turns the instruction decoder's ID, metadata and XON/XOFF strobes, plus captured 32-bit sample words, into a byte stream on a valid/ready interface toward the UART transmitter. It sends the ID string, the metadata block, and sample words with disabled channel groups removed.

Parameters:
NUM_PROBES, 32, probe count reported in metadata key 0x20
SMPL_MEM_BYTES, 4096, sample memory size in bytes, reported in key 0x21
MAX_RATE, 100000000, maximum sample rate in Hz, reported in key 0x23

Ports:
clk_i  in  1  system clock
rst_in  in  1  asynchronous active-low reset
sft_rst_i  in  1  synchronous soft reset pulse from the decoder
id_i  in  1  one-cycle pulse: send the ID string
rd_meta_i  in  1  one-cycle pulse: send the metadata block
xon_i  in  1  one-cycle pulse: resume output
xoff_i  in  1  one-cycle pulse: pause output
grp_en_i  in  4  channel-group enable; bit i enables byte i of each sample word
dat_i  in  32  sample word
dat_stb_i  in  1  sample word valid
dat_rdy_o  out  1  sample word can be accepted this cycle
tx_dat_o  out  8  byte to the UART
tx_stb_o  out  1  tx_dat_o valid
tx_rdy_i  in  1  UART accepts the byte
busy_o  out  1  state is not IDLE, or a request is pending

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE, tx_stb_o=0, tx_dat_o=0x00, pause=0, pend_id=0, pend_meta=0, byte index=0. After reset dat_rdy_o=1 and busy_o=0.
- sft_rst_i: same clear as reset, taken synchronously, highest priority. An in-flight byte is dropped (tx_stb_o=0 next cycle).
- States: IDLE, ID, META, WORD. A 5-bit byte index counts inside each state.
- Byte handshake: a byte transfers on a rising edge where tx_stb_o=1 and tx_rdy_i=1. While tx_stb_o=1, tx_dat_o stays stable. The next byte may be presented in the cycle right after the transfer, giving back-to-back bytes when tx_rdy_i stays high.
- Pause:
  - xoff_i sets pause; xon_i clears it; if both arrive in the same cycle, xoff wins.
  - While paused, no new byte is presented. A byte already presented (tx_stb_o=1) stays until it transfers.
- Requests:
  - id_i sets pend_id and rd_meta_i sets pend_meta, in any state.
  - In IDLE: pend_id is served first (go to ID, clear pend_id), then pend_meta (go to META).
  - A sample word is accepted only when no request is pending.
- dat_rdy_o = (state==IDLE) and not pend_id and not pend_meta and not sft_rst_i. This output is combinational.
- Word acceptance:
  - On an edge with dat_stb_i and dat_rdy_o, dat_i and grp_en_i are latched and the block enters WORD.
  - The first byte appears on tx_stb_o in the next cycle, i.e. 1 cycle latency.
- ID sequence: 0x31 0x41 0x4C 0x53 ("1ALS"), then IDLE.
- META sequence, 23 bytes, then IDLE:
  - 0x01 followed by "logIP" and a NUL: 0x6C 0x6F 0x67 0x49 0x50 0x00.
  - 0x20 followed by NUM_PROBES as 32 bits, big-endian.
  - 0x21 followed by SMPL_MEM_BYTES as 32 bits, big-endian.
  - 0x23 followed by MAX_RATE as 32 bits, big-endian.
  - 0x00 end marker.
- WORD sequence:
  - Bytes are sent LSB group first: dat[7:0], dat[15:8], dat[23:16], dat[31:24].
  - Groups whose latched grp_en bit is 0 are skipped with no idle cycle.
  - grp_en=0000: the word is consumed, no bytes are sent, and the block returns to IDLE on the next edge.
- Back in IDLE, pending requests are checked before dat_rdy_o rises. Requests that arrive mid-sequence never interrupt the current sequence.
- Duplicate id_i pulses while pend_id is already set collapse into one ID response; the same holds for rd_meta_i.
- busy_o = (state!=IDLE) or pend_id or pend_meta.

Test Plan:
1. id_i pulse, tx_rdy_i=1 -> bytes 0x31,0x41,0x4C,0x53 on 4 consecutive cycles; busy_o low afterwards.
2. rd_meta_i pulse, tx_rdy_i toggling every other cycle -> all 23 metadata bytes in order, with key 0x20 carrying 0x00,0x00,0x00,0x20; tx_dat_o stable whenever tx_stb_o=1 and tx_rdy_i=0.
3. grp_en_i=0101, dat_i=0xDDCCBBAA, dat_stb_i -> exactly 0xAA then 0xCC; dat_rdy_o re-asserts after the last transfer. With grp_en_i=0000, dat_rdy_o drops for one cycle and no tx_stb_o is seen.
4. xoff_i after the first byte of word 0x44332211 (all groups enabled) -> 0x11 sent, nothing for 20 cycles; after xon_i, 0x22,0x33,0x44 follow. xon_i and xoff_i in the same cycle -> remains paused.
5. id_i during a WORD transfer -> word completes, then "1ALS"; a dat_stb_i held high is not accepted until the ID finishes.
6. sft_rst_i at metadata byte 10 -> tx_stb_o=0 next cycle, state IDLE, pend flags clear. rst_in low mid-word -> all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/resp_tx.sv
// resp_tx - response transmitter for the SUMP-compatible analyzer.
//
// Serialises decoder responses into a byte stream for the UART transmitter:
//   * ID string "1ALS" on an id_i pulse
//   * 23-byte metadata block on an rd_meta_i pulse
//   * captured 32-bit sample words, LSB group first, skipping disabled groups
// Output is paused by xoff_i and resumed by xon_i.
//
// Ports:
//   clk_i      system clock
//   rst_in     asynchronous active-low reset
//   sft_rst_i  synchronous soft reset (highest priority)
//   id_i       pulse: queue the ID string
//   rd_meta_i  pulse: queue the metadata block
//   xon_i      pulse: resume output
//   xoff_i     pulse: pause output (wins over xon_i)
//   grp_en_i   channel-group enables, bit i keeps byte i of a sample word
//   dat_i      sample word
//   dat_stb_i  sample word valid
//   dat_rdy_o  sample word accepted this cycle if dat_stb_i is high
//   tx_dat_o   byte to the UART
//   tx_stb_o   tx_dat_o valid
//   tx_rdy_i   UART accepts the byte
//   busy_o     a sequence is running or a request is pending
module resp_tx #(
    parameter int unsigned NUM_PROBES     = 32,
    parameter int unsigned SMPL_MEM_BYTES = 4096,
    parameter int unsigned MAX_RATE       = 100000000
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        sft_rst_i,
    input  logic        id_i,
    input  logic        rd_meta_i,
    input  logic        xon_i,
    input  logic        xoff_i,
    input  logic [3:0]  grp_en_i,
    input  logic [31:0] dat_i,
    input  logic        dat_stb_i,
    output logic        dat_rdy_o,
    output logic [7:0]  tx_dat_o,
    output logic        tx_stb_o,
    input  logic        tx_rdy_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ID   = 2'd1,
        ST_META = 2'd2,
        ST_WORD = 2'd3
    } state_t;

    localparam logic [4:0]  ID_LEN   = 5'd4;
    localparam logic [4:0]  META_LEN = 5'd23;
    localparam logic [31:0] PROBES_W = 32'(NUM_PROBES);
    localparam logic [31:0] MEM_W    = 32'(SMPL_MEM_BYTES);
    localparam logic [31:0] RATE_W   = 32'(MAX_RATE);

    function automatic logic [7:0] id_byte(input logic [1:0] i);
        case (i)
            2'd0:    id_byte = 8'h31;
            2'd1:    id_byte = 8'h41;
            2'd2:    id_byte = 8'h4C;
            default: id_byte = 8'h53;
        endcase
    endfunction

    // Metadata: device name, then three 32-bit big-endian keys, then end marker.
    function automatic logic [7:0] meta_byte(input logic [4:0] i);
        case (i)
            5'd0:    meta_byte = 8'h01;
            5'd1:    meta_byte = 8'h6C;
            5'd2:    meta_byte = 8'h6F;
            5'd3:    meta_byte = 8'h67;
            5'd4:    meta_byte = 8'h49;
            5'd5:    meta_byte = 8'h50;
            5'd6:    meta_byte = 8'h00;
            5'd7:    meta_byte = 8'h20;
            5'd8:    meta_byte = PROBES_W[31:24];
            5'd9:    meta_byte = PROBES_W[23:16];
            5'd10:   meta_byte = PROBES_W[15:8];
            5'd11:   meta_byte = PROBES_W[7:0];
            5'd12:   meta_byte = 8'h21;
            5'd13:   meta_byte = MEM_W[31:24];
            5'd14:   meta_byte = MEM_W[23:16];
            5'd15:   meta_byte = MEM_W[15:8];
            5'd16:   meta_byte = MEM_W[7:0];
            5'd17:   meta_byte = 8'h23;
            5'd18:   meta_byte = RATE_W[31:24];
            5'd19:   meta_byte = RATE_W[23:16];
            5'd20:   meta_byte = RATE_W[15:8];
            5'd21:   meta_byte = RATE_W[7:0];
            default: meta_byte = 8'h00;
        endcase
    endfunction

    state_t      state_reg, state_next, seq_state;
    logic [4:0]  idx_reg, idx_next, seq_idx;
    logic [3:0]  rem_reg, rem_next, seq_rem;     // groups of the word still to send
    logic [31:0] word_reg, word_next, word_eff;
    logic        tx_stb_reg, tx_stb_next;
    logic [7:0]  tx_dat_reg, tx_dat_next, seq_byte;
    logic        pause_reg, pause_next;
    logic        pend_id_reg, pend_id_next;
    logic        pend_meta_reg, pend_meta_next;
    logic        slot_free, seq_have, can_accept;
    logic [1:0]  low_sel;
    logic [7:0]  lane [4];

    assign can_accept = (state_reg == ST_IDLE) && !pend_id_reg && !pend_meta_reg;
    assign dat_rdy_o  = can_accept && !sft_rst_i;
    assign busy_o     = (state_reg != ST_IDLE) || pend_id_reg || pend_meta_reg;
    assign tx_stb_o   = tx_stb_reg;
    assign tx_dat_o   = tx_dat_reg;

    // The first byte of a word is taken straight from dat_i on the accepting
    // edge, so the lanes look at the incoming word while a word can be accepted.
    assign word_eff = can_accept ? dat_i : word_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = word_eff[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        rem_next       = rem_reg;
        word_next      = word_reg;
        tx_stb_next    = tx_stb_reg;
        tx_dat_next    = tx_dat_reg;
        pend_id_next   = pend_id_reg | id_i;
        pend_meta_next = pend_meta_reg | rd_meta_i;
        seq_state      = state_reg;
        seq_idx        = idx_reg;
        seq_rem        = rem_reg;
        seq_have       = 1'b0;
        seq_byte       = 8'h00;
        low_sel        = 2'd0;

        if (xoff_i)     pause_next = 1'b1;
        else if (xon_i) pause_next = 1'b0;
        else            pause_next = pause_reg;

        // The output slot can take a new byte if empty or emptying on this edge.
        slot_free = !tx_stb_reg || tx_rdy_i;
        if (tx_stb_reg && tx_rdy_i) tx_stb_next = 1'b0;

        // In IDLE, pick the sequence to start; its first byte can go out now.
        // A request pulse coinciding with its own service collapses into it.
        if (state_reg == ST_IDLE) begin
            if (pend_id_reg) begin
                seq_state    = ST_ID;
                seq_idx      = 5'd0;
                pend_id_next = 1'b0;
            end else if (pend_meta_reg) begin
                seq_state      = ST_META;
                seq_idx        = 5'd0;
                pend_meta_next = 1'b0;
            end else if (dat_stb_i) begin
                seq_state = ST_WORD;
                seq_rem   = grp_en_i;
                word_next = dat_i;
            end
        end

        for (int i = 3; i >= 0; i--) begin
            if (seq_rem[i]) low_sel = 2'(i);
        end

        case (seq_state)
            ST_ID: begin
                seq_have = (seq_idx < ID_LEN);
                seq_byte = id_byte(seq_idx[1:0]);
            end
            ST_META: begin
                seq_have = (seq_idx < META_LEN);
                seq_byte = meta_byte(seq_idx);
            end
            ST_WORD: begin
                seq_have = |seq_rem;
                seq_byte = lane[low_sel];
            end
            default: ;
        endcase

        if (seq_state != ST_IDLE && slot_free) begin
            if (seq_have && !pause_next) begin
                state_next  = seq_state;
                idx_next    = seq_idx + 5'd1;
                rem_next    = seq_rem & ~(4'b0001 << low_sel);
                tx_stb_next = 1'b1;
                tx_dat_next = seq_byte;
            end else if (!seq_have && state_reg != ST_IDLE) begin
                // Last byte has left (or an empty word): back to IDLE; pending
                // requests are looked at from IDLE on the following edge.
                state_next = ST_IDLE;
                idx_next   = 5'd0;
                rem_next   = 4'd0;
            end else begin
                state_next = seq_state;
                idx_next   = seq_idx;
                rem_next   = seq_rem;
            end
        end

        if (sft_rst_i) begin
            state_next     = ST_IDLE;
            idx_next       = 5'd0;
            rem_next       = 4'd0;
            word_next      = 32'd0;
            tx_stb_next    = 1'b0;
            tx_dat_next    = 8'h00;
            pause_next     = 1'b0;
            pend_id_next   = 1'b0;
            pend_meta_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= 5'd0;
            rem_reg       <= 4'd0;
            word_reg      <= 32'd0;
            tx_stb_reg    <= 1'b0;
            tx_dat_reg    <= 8'h00;
            pause_reg     <= 1'b0;
            pend_id_reg   <= 1'b0;
            pend_meta_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            rem_reg       <= rem_next;
            word_reg      <= word_next;
            tx_stb_reg    <= tx_stb_next;
            tx_dat_reg    <= tx_dat_next;
            pause_reg     <= pause_next;
            pend_id_reg   <= pend_id_next;
            pend_meta_reg <= pend_meta_next;
        end
    end

endmodule

// File: tb/tb_resp_tx.sv
module tb_resp_tx;
    localparam int unsigned NP = 32;
    localparam int unsigned SM = 4096;
    localparam int unsigned MR = 100000000;

    logic        clk_i = 1'b0;
    logic        rst_in = 1'b0;
    logic        sft_rst_i = 1'b0;
    logic        id_i = 1'b0;
    logic        rd_meta_i = 1'b0;
    logic        xon_i = 1'b0;
    logic        xoff_i = 1'b0;
    logic [3:0]  grp_en_i = 4'd0;
    logic [31:0] dat_i = 32'd0;
    logic        dat_stb_i = 1'b0;
    logic        dat_rdy_o;
    logic [7:0]  tx_dat_o;
    logic        tx_stb_o;
    logic        tx_rdy_i = 1'b0;
    logic        busy_o;

    resp_tx #(.NUM_PROBES(NP), .SMPL_MEM_BYTES(SM), .MAX_RATE(MR)) dut (
        .clk_i(clk_i), .rst_in(rst_in), .sft_rst_i(sft_rst_i),
        .id_i(id_i), .rd_meta_i(rd_meta_i), .xon_i(xon_i), .xoff_i(xoff_i),
        .grp_en_i(grp_en_i), .dat_i(dat_i), .dat_stb_i(dat_stb_i),
        .dat_rdy_o(dat_rdy_o), .tx_dat_o(tx_dat_o), .tx_stb_o(tx_stb_o),
        .tx_rdy_i(tx_rdy_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 never ready
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         got_cyc [$];
    logic       pause_m = 1'b0;
    logic       prev_stb = 1'b0;
    logic       prev_xfer = 1'b0;
    logic [7:0] prev_dat = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: expected byte stream ----------------
    task automatic push_id();
        exp_q.push_back(8'h31); exp_q.push_back(8'h41);
        exp_q.push_back(8'h4C); exp_q.push_back(8'h53);
    endtask

    task automatic push_key(input logic [7:0] key, input logic [31:0] v);
        exp_q.push_back(key);
        for (int s = 24; s >= 0; s -= 8) exp_q.push_back(v[s +: 8]);
    endtask

    task automatic push_meta();
        logic [7:0] name [6] = '{8'h01, 8'h6C, 8'h6F, 8'h67, 8'h49, 8'h50};
        for (int i = 0; i < 6; i++) exp_q.push_back(name[i]);
        exp_q.push_back(8'h00);
        push_key(8'h20, 32'(NP));
        push_key(8'h21, 32'(SM));
        push_key(8'h23, 32'(MR));
        exp_q.push_back(8'h00);
    endtask

    task automatic push_word(input logic [31:0] d, input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) exp_q.push_back(d[8*i +: 8]);
    endtask

    // ---------------- monitor / compare process ----------------
    initial forever begin
        @(negedge clk_i);
        cyc++;
        if (!rst_in || sft_rst_i) begin
            exp_q.delete();
            pause_m   = 1'b0;
            prev_stb  = 1'b0;
            prev_xfer = 1'b0;
        end else begin
            if (tx_stb_o && prev_stb && !prev_xfer) chk("hold_stable", {24'd0, tx_dat_o}, {24'd0, prev_dat});
            if (tx_stb_o && (!prev_stb || prev_xfer)) chk("no_new_byte_while_paused", {31'd0, pause_m}, 32'd0);
            if (tx_stb_o && tx_rdy_i) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte", tx_dat_o);
                end else begin
                    chk("byte", {24'd0, tx_dat_o}, {24'd0, exp_q.pop_front()});
                end
                got_q.push_back(tx_dat_o);
                got_cyc.push_back(cyc);
            end
            prev_stb  = tx_stb_o;
            prev_xfer = tx_stb_o && tx_rdy_i;
            prev_dat  = tx_dat_o;
            pause_m   = xoff_i ? 1'b1 : (xon_i ? 1'b0 : pause_m);
        end
    end

    // UART ready driver
    initial forever begin
        @(posedge clk_i);
        #1;
        case (rdy_mode)
            0:       tx_rdy_i = 1'b1;
            1:       tx_rdy_i = ~tx_rdy_i;
            2:       tx_rdy_i = 1'($urandom_range(0, 1));
            default: tx_rdy_i = 1'b0;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_id(input bit push);
        id_i = 1'b1;
        if (push) push_id();
        tick();
        id_i = 1'b0;
    endtask

    task automatic pulse_meta();
        rd_meta_i = 1'b1;
        push_meta();
        tick();
        rd_meta_i = 1'b0;
    endtask

    task automatic pulse_pause(input logic on, input logic off);
        xon_i = on; xoff_i = off;
        tick();
        xon_i = 1'b0; xoff_i = 1'b0;
    endtask

    // Hold dat_stb_i until the word is taken; returns at posedge+1 after acceptance.
    task automatic send_word(input logic [31:0] d, input logic [3:0] g);
        bit acc = 0;
        dat_i = d; grp_en_i = g; dat_stb_i = 1'b1;
        for (int n = 0; n < 3000 && !acc; n++) begin
            @(negedge clk_i);
            if (dat_rdy_o) begin
                acc = 1;
                chk("accept_only_when_drained", 32'(exp_q.size()), 32'd0);
            end
        end
        tick();
        dat_stb_i = 1'b0;
        if (acc) push_word(d, g);
        else begin
            tests++; fails++;
            $display("FAIL word_accept_timeout: got dat_rdy_o=0, expected 1");
        end
    endtask

    task automatic wait_done();
        bit done = 0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk_i);
            if (!busy_o && exp_q.size() == 0) done = 1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL done_timeout: got busy_o=%0d pending=%0d, expected 0/0", busy_o, exp_q.size());
        end
        chk("idle_busy", {31'd0, busy_o}, 32'd0);
        chk("idle_dat_rdy", {31'd0, dat_rdy_o}, 32'd1);
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n0;
        int k;
        // reset values (while held and after release)
        #12;
        chk("rst_tx_stb", {31'd0, tx_stb_o}, 32'd0);
        chk("rst_tx_dat", {24'd0, tx_dat_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_dat_rdy", {31'd0, dat_rdy_o}, 32'd1);
        repeat (2) tick();
        rst_in = 1'b1;
        tick();

        // 1: ID string back-to-back
        rdy_mode = 0;
        got_q.delete(); got_cyc.delete();
        pulse_id(1);
        wait_done();
        chk("id_len", 32'(got_q.size()), 32'd4);
        chk("id_b0", {24'd0, got_q[0]}, 32'h31);
        chk("id_b1", {24'd0, got_q[1]}, 32'h41);
        chk("id_b2", {24'd0, got_q[2]}, 32'h4C);
        chk("id_b3", {24'd0, got_q[3]}, 32'h53);
        chk("id_back_to_back", 32'(got_cyc[3] - got_cyc[0]), 32'd3);

        // 2: metadata with stalling UART
        rdy_mode = 1;
        got_q.delete();
        pulse_meta();
        wait_done();
        chk("meta_len", 32'(got_q.size()), 32'd23);
        chk("meta_b0", {24'd0, got_q[0]}, 32'h01);
        chk("meta_key20", {24'd0, got_q[7]}, 32'h20);
        chk("meta_probes", {got_q[8], got_q[9], got_q[10], got_q[11]}, 32'h0000_0020);
        chk("meta_mem", {got_q[13], got_q[14], got_q[15], got_q[16]}, 32'h0000_1000);
        chk("meta_rate", {got_q[18], got_q[19], got_q[20], got_q[21]}, 32'h05F5_E100);
        chk("meta_end", {24'd0, got_q[22]}, 32'h00);

        // 3: group skipping, and the empty word
        rdy_mode = 2;
        got_q.delete();
        send_word(32'hDDCC_BBAA, 4'b0101);
        wait_done();
        chk("grp_len", 32'(got_q.size()), 32'd2);
        chk("grp_b0", {24'd0, got_q[0]}, 32'hAA);
        chk("grp_b1", {24'd0, got_q[1]}, 32'hCC);
        send_word(32'h1234_5678, 4'b0000);
        @(negedge clk_i);
        chk("empty_rdy_low", {31'd0, dat_rdy_o}, 32'd0);
        chk("empty_no_stb", {31'd0, tx_stb_o}, 32'd0);
        @(negedge clk_i);
        chk("empty_rdy_back", {31'd0, dat_rdy_o}, 32'd1);
        chk("empty_no_stb2", {31'd0, tx_stb_o}, 32'd0);
        tick();

        // 4: pause after the first byte; xon+xoff together stays paused
        rdy_mode = 0;
        got_q.delete();
        send_word(32'h4433_2211, 4'b1111);
        pulse_pause(1'b0, 1'b1);
        repeat (20) tick();
        chk("paused_count", 32'(got_q.size()), 32'd1);
        chk("paused_first", {24'd0, got_q[0]}, 32'h11);
        pulse_pause(1'b1, 1'b1);
        repeat (5) tick();
        chk("both_still_paused", 32'(got_q.size()), 32'd1);
        pulse_pause(1'b1, 1'b0);
        wait_done();
        chk("resume_len", 32'(got_q.size()), 32'd4);
        chk("resume_b1", {24'd0, got_q[1]}, 32'h22);
        chk("resume_b3", {24'd0, got_q[3]}, 32'h44);

        // 5: ID (duplicated pulse) during a word; held word waits for the ID
        rdy_mode = 2;
        send_word(32'hA1B2_C3D4, 4'b1111);
        pulse_id(1);
        pulse_id(0);
        send_word(32'h5566_7788, 4'b1010);
        wait_done();

        // 6a: soft reset mid-metadata
        rdy_mode = 0;
        got_q.delete();
        pulse_meta();
        for (int n = 0; n < 200 && got_q.size() < 10; n++) @(negedge clk_i);
        tick();
        sft_rst_i = 1'b1;
        n0 = got_q.size();
        tick();
        sft_rst_i = 1'b0;
        @(negedge clk_i);
        chk("sft_stb", {31'd0, tx_stb_o}, 32'd0);
        chk("sft_busy", {31'd0, busy_o}, 32'd0);
        chk("sft_dat_rdy", {31'd0, dat_rdy_o}, 32'd1);
        repeat (5) tick();
        chk("sft_no_more", 32'(got_q.size()), 32'(n0));

        // 6b: asynchronous reset mid-word
        rdy_mode = 3;
        send_word(32'hDEAD_BEEF, 4'b1111);
        tick();
        #2;
        rst_in = 1'b0;
        #1;
        chk("arst_stb", {31'd0, tx_stb_o}, 32'd0);
        chk("arst_dat", {24'd0, tx_dat_o}, 32'd0);
        chk("arst_busy", {31'd0, busy_o}, 32'd0);
        chk("arst_dat_rdy", {31'd0, dat_rdy_o}, 32'd1);
        repeat (2) tick();
        rst_in = 1'b1;
        tick();

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            rdy_mode = $urandom_range(0, 2);
            k = $urandom_range(0, 4);
            case (k)
                0: pulse_id(1);
                1: pulse_meta();
                2: begin
                    id_i = 1'b1; rd_meta_i = 1'b1;
                    push_id(); push_meta();
                    tick();
                    id_i = 1'b0; rd_meta_i = 1'b0;
                end
                default: send_word($urandom, 4'($urandom_range(0, 15)));
            endcase
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 4)) tick();
                pulse_pause(1'b0, 1'b1);
                repeat ($urandom_range(0, 12)) tick();
                pulse_pause(1'b1, 1'b0);
            end
            wait_done();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
